// File: rtl/score_display_ctrl.sv
// Score/high-score keeper for the game screen: BCD score with saturation at 99,
// high-score capture at game over, and frame-synchronous 7-segment patterns.
module score_display_ctrl #(
  parameter bit BLANK_LZ = 1'b0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        frame_tick,
  input  logic        point,
  input  logic        game_start,
  input  logic        game_over,
  output logic [13:0] seg,
  output logic [13:0] seg_high,
  output logic        new_high,
  output logic [1:0]  state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    OVER = 2'd2
  } state_t;

  localparam logic [13:0] RST_SEG = BLANK_LZ ? 14'h007E : 14'h3F7E;

  state_t     cur_state;
  logic [3:0] sc_t, sc_u, hi_t, hi_u;
  logic [3:0] inc_t, inc_u, eff_t, eff_u;
  logic       beats_high;
  logic [13:0] seg_next, seg_high_next;

  function automatic logic [6:0] enc7(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'h7E;
      4'd1:    s = 7'h30;
      4'd2:    s = 7'h6D;
      4'd3:    s = 7'h79;
      4'd4:    s = 7'h33;
      4'd5:    s = 7'h5B;
      4'd6:    s = 7'h5F;
      4'd7:    s = 7'h70;
      4'd8:    s = 7'h7F;
      4'd9:    s = 7'h7B;
      default: s = 7'h00;
    endcase
    return s;
  endfunction

  function automatic logic [13:0] enc_pair(input logic [3:0] t, input logic [3:0] u);
    logic [6:0] tens;
    tens = (BLANK_LZ && (t == 4'd0)) ? 7'h00 : enc7(t);
    return {tens, enc7(u)};
  endfunction

  // The game-over comparison uses the score including a same-cycle point.
  always_comb begin
    inc_t = sc_t;
    inc_u = sc_u;
    if ((sc_t == 4'd9) && (sc_u == 4'd9)) begin
      inc_t = sc_t;
      inc_u = sc_u;
    end else if (sc_u == 4'd9) begin
      inc_u = 4'd0;
      inc_t = sc_t + 4'd1;
    end else begin
      inc_u = sc_u + 4'd1;
    end
    eff_t         = point ? inc_t : sc_t;
    eff_u         = point ? inc_u : sc_u;
    beats_high    = {eff_t, eff_u} > {hi_t, hi_u};
    seg_next      = enc_pair(sc_t, sc_u);
    seg_high_next = enc_pair(hi_t, hi_u);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_state <= IDLE;
      sc_t      <= 4'd0;
      sc_u      <= 4'd0;
      hi_t      <= 4'd0;
      hi_u      <= 4'd0;
      new_high  <= 1'b0;
    end else begin
      case (cur_state)
        IDLE, OVER: begin
          if (game_start) begin
            sc_t      <= 4'd0;
            sc_u      <= 4'd0;
            new_high  <= 1'b0;
            cur_state <= PLAY;
          end
        end
        PLAY: begin
          sc_t <= eff_t;
          sc_u <= eff_u;
          if (game_over) begin
            if (beats_high) begin
              hi_t     <= eff_t;
              hi_u     <= eff_u;
              new_high <= 1'b1;
            end
            cur_state <= OVER;
          end
        end
        default: cur_state <= IDLE;
      endcase
    end
  end

  // Patterns only move at the frame boundary so a digit never tears mid-frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg      <= RST_SEG;
      seg_high <= RST_SEG;
    end else if (frame_tick) begin
      seg      <= seg_next;
      seg_high <= seg_high_next;
    end
  end

  assign state = cur_state;

endmodule

// File: tb/tb_score_display_ctrl.sv
// Bench for score_display_ctrl: directed vector table, hand-written corner sequences,
// and random pulses checked against an integer-level score model.
module tb_score_display_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        frame_tick = 1'b0;
  logic        point = 1'b0;
  logic        game_start = 1'b0;
  logic        game_over = 1'b0;
  logic [13:0] seg, seg_high, seg_b, seg_high_b;
  logic        new_high, new_high_b;
  logic [1:0]  state, state_b;

  always #5 clk = ~clk;

  score_display_ctrl #(.BLANK_LZ(1'b0)) dut (
    .clk(clk), .rst_n(rst_n), .frame_tick(frame_tick), .point(point),
    .game_start(game_start), .game_over(game_over),
    .seg(seg), .seg_high(seg_high), .new_high(new_high), .state(state)
  );

  score_display_ctrl #(.BLANK_LZ(1'b1)) dut_b (
    .clk(clk), .rst_n(rst_n), .frame_tick(frame_tick), .point(point),
    .game_start(game_start), .game_over(game_over),
    .seg(seg_b), .seg_high(seg_high_b), .new_high(new_high_b), .state(state_b)
  );

  typedef struct packed {
    logic        ft, p, gs, go;
    logic [1:0]  st;
    logic        nh;
    logic [13:0] sg, sh;
  } vec_t;

  logic [6:0] enc_tbl [10] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33,
                               7'h5B, 7'h5F, 7'h70, 7'h7F, 7'h7B};

  int n_cmp = 0;
  int n_fail = 0;

  // Model: mode 0 idle, 1 playing, 2 game over; scores as plain integers.
  int m_mode, m_score, m_hi, m_nh, m_dsc, m_dhi;

  function automatic logic [13:0] exp_seg(int v, bit blank);
    int t;
    int u;
    logic [6:0] tf;
    t  = v / 10;
    u  = v % 10;
    tf = (blank && t == 0) ? 7'h00 : enc_tbl[t];
    return {tf, enc_tbl[u]};
  endfunction

  task automatic modelReset();
    m_mode = 0; m_score = 0; m_hi = 0; m_nh = 0; m_dsc = 0; m_dhi = 0;
  endtask

  task automatic checkOutput(input string name, input logic [13:0] act, input logic [13:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic checkAll(input string tag);
    checkOutput({tag, " state"},      {12'b0, state},      14'(m_mode));
    checkOutput({tag, " state_b"},    {12'b0, state_b},    14'(m_mode));
    checkOutput({tag, " new_high"},   {13'b0, new_high},   14'(m_nh));
    checkOutput({tag, " new_high_b"}, {13'b0, new_high_b}, 14'(m_nh));
    checkOutput({tag, " seg"},        seg,        exp_seg(m_dsc, 1'b0));
    checkOutput({tag, " seg_high"},   seg_high,   exp_seg(m_dhi, 1'b0));
    checkOutput({tag, " seg_b"},      seg_b,      exp_seg(m_dsc, 1'b1));
    checkOutput({tag, " seg_high_b"}, seg_high_b, exp_seg(m_dhi, 1'b1));
  endtask

  // Drives one cycle of pulses, advances the model at the edge, samples 1ns later.
  task automatic applyStimulus(input logic ft, input logic p, input logic gs, input logic go);
    frame_tick = ft; point = p; game_start = gs; game_over = go;
    @(posedge clk);
    if (ft) begin
      m_dsc = m_score;
      m_dhi = m_hi;
    end
    if (m_mode == 1) begin
      if (p && m_score < 99) m_score++;
      if (go) begin
        if (m_score > m_hi) begin
          m_hi = m_score;
          m_nh = 1;
        end else begin
          m_nh = 0;
        end
        m_mode = 2;
      end
    end else if (gs) begin
      m_score = 0;
      m_nh    = 0;
      m_mode  = 1;
    end
    #1;
  endtask

  task automatic points(input int n);
    repeat (n) applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic doReset();
    frame_tick = 1'b0; point = 1'b0; game_start = 1'b0; game_over = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    modelReset();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  vec_t vecs [9];

  initial begin
    vecs[0] = '{1'b0, 1'b0, 1'b1, 1'b0, 2'd1, 1'b0, 14'h3F7E, 14'h3F7E};
    vecs[1] = '{1'b0, 1'b1, 1'b0, 1'b0, 2'd1, 1'b0, 14'h3F7E, 14'h3F7E};
    vecs[2] = '{1'b0, 1'b1, 1'b0, 1'b0, 2'd1, 1'b0, 14'h3F7E, 14'h3F7E};
    vecs[3] = '{1'b1, 1'b0, 1'b0, 1'b0, 2'd1, 1'b0, 14'h3F6D, 14'h3F7E};
    vecs[4] = '{1'b0, 1'b0, 1'b1, 1'b0, 2'd1, 1'b0, 14'h3F6D, 14'h3F7E};
    vecs[5] = '{1'b0, 1'b0, 1'b0, 1'b1, 2'd2, 1'b1, 14'h3F6D, 14'h3F7E};
    vecs[6] = '{1'b1, 1'b1, 1'b0, 1'b0, 2'd2, 1'b1, 14'h3F6D, 14'h3F6D};
    vecs[7] = '{1'b0, 1'b1, 1'b1, 1'b0, 2'd1, 1'b0, 14'h3F6D, 14'h3F6D};
    vecs[8] = '{1'b1, 1'b0, 1'b0, 1'b0, 2'd1, 1'b0, 14'h3F7E, 14'h3F6D};

    modelReset();
    #12;
    checkOutput("reset seg",      seg,        14'h3F7E);
    checkOutput("reset seg_high", seg_high,   14'h3F7E);
    checkOutput("reset seg_b",    seg_b,      14'h007E);
    checkOutput("reset state",    {12'b0, state}, 14'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 9; i++) begin
      applyStimulus(vecs[i].ft, vecs[i].p, vecs[i].gs, vecs[i].go);
      checkOutput($sformatf("vec%0d state", i), {12'b0, state}, {12'b0, vecs[i].st});
      checkOutput($sformatf("vec%0d new_high", i), {13'b0, new_high}, {13'b0, vecs[i].nh});
      checkOutput($sformatf("vec%0d seg", i), seg, vecs[i].sg);
      checkOutput($sformatf("vec%0d seg_high", i), seg_high, vecs[i].sh);
    end

    // Counting to 12 and the blanked-tens view of a single-digit score.
    doReset();
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    points(7);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput("blank seg_b 7", seg_b, 14'h0070);
    checkOutput("unblank seg 7", seg, 14'h3F70);
    points(5);
    checkOutput("count pre-tick seg", seg, 14'h3F70);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
    checkOutput("tick with point shows old", seg, 14'h186D);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    checkAll("count13");

    // Saturation at 99.
    points(105);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput("saturate seg", seg, 14'h3DFB);
    points(3);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput("saturate hold seg", seg, 14'h3DFB);

    // Asynchronous reset mid-game at score 37, observed between edges.
    doReset();
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    points(37);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput("score37 seg", seg, 14'h3CF0);
    frame_tick = 1'b0; point = 1'b0; game_start = 1'b0; game_over = 1'b0;
    #2;
    rst_n = 1'b0;
    modelReset();
    #1;
    checkOutput("async rst seg",      seg,      14'h3F7E);
    checkOutput("async rst seg_high", seg_high, 14'h3F7E);
    checkOutput("async rst seg_b",    seg_b,    14'h007E);
    checkOutput("async rst state",    {12'b0, state}, 14'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // High score: 15 sets it, a second 15 ties and does not.
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    points(15);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    checkOutput("high first nh", {13'b0, new_high}, 14'd1);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput("high first seg_high", seg_high, 14'h185B);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    points(15);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput("high tie nh", {13'b0, new_high}, 14'd0);
    checkOutput("high tie seg_high", seg_high, 14'h185B);

    // Point together with game_over, then start together with point.
    doReset();
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    points(9);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    points(9);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1);
    checkOutput("same-cycle nh", {13'b0, new_high}, 14'd1);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput("same-cycle seg_high", seg_high, 14'h187E);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
    checkOutput("start+point state", {12'b0, state}, 14'd1);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput("start+point seg", seg, 14'h3F7E);
    checkAll("start+point");

    // Random pulse traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      applyStimulus(1'($urandom_range(7) == 0), 1'($urandom_range(1)),
                    1'($urandom_range(29) == 0), 1'($urandom_range(39) == 0));
      checkAll($sformatf("rand%0d", i));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
